scalar_mult_ctrl: RTL and testbench
===================================

SCALAR_MULT_CTRL -- requirements
Module: scalar_mult_ctrl

Interface
REQ-001 SHALL have parameter n, default 231, operand/coordinate width.
REQ-002 SHALL have parameter IDX_W, default 8, scalar bit-index width (2^IDX_W >= n).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request; samples k, px, py.
REQ-006 k, px, py  input  n each  scalar; base point P = (px, py).
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 x_out, y_out  output  n each  result Q = kP.
REQ-010 inf_out  output  1  Q is the point at infinity.
REQ-011 dbl_start  output  1; dbl_x, dbl_y  output  n: request to point_doubling.
REQ-012 dbl_done, dbl_inf  input  1; dbl_x3, dbl_y3  input  n: doubling result.
REQ-013 add_start  output  1; add_x1, add_y1, add_x2, add_y2  output  n: request to point-addition unit.
REQ-014 add_done, add_inf  input  1; add_x3, add_y3  input  n: addition result.

Function
REQ-015 SHALL implement left-to-right double-and-add over k, MSB first.
REQ-016 FSM states SHALL be IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_CHK, ADD_REQ, ADD_WAIT, FIN.
REQ-017 IDLE: start=1 SHALL latch k, px, py, set idx=n-1, enter SCAN; start SHALL be ignored in all other states.
REQ-018 SCAN SHALL test one bit per cycle: bit=0 and idx>0 -> idx-1; bit=1 -> Q=P, q_inf=0, then DBL_REQ if idx>0 else FIN; bit=0 at idx=0 -> Q=inf, FIN.
REQ-019 DBL_REQ SHALL decrement idx, pulse dbl_start for exactly one cycle with dbl_x/dbl_y=Q, enter DBL_WAIT; if q_inf=1 it SHALL skip the request and go straight to ADD_CHK.
REQ-020 dbl_x/dbl_y and add_* operands SHALL be held stable from the start pulse until the matching done is sampled.
REQ-021 DBL_WAIT: dbl_done=1 SHALL load Q=(dbl_x3,dbl_y3), q_inf=dbl_inf, enter ADD_CHK.
REQ-022 ADD_CHK: k[idx]=0 -> next; q_inf=1 -> Q=P, q_inf=0, next; Q==P -> issue doubling of Q (DBL path reused, idx unchanged, return to ADD_CHK skipped bit); qx==px, qy!=py -> q_inf=1, next; otherwise ADD_REQ.
REQ-023 "next" SHALL mean FIN when idx=0, else DBL_REQ.
REQ-024 ADD_REQ SHALL pulse add_start one cycle with (Q, P); ADD_WAIT on add_done SHALL load Q=(add_x3,add_y3), q_inf=add_inf, then next.
REQ-025 dbl_done/add_done outside their WAIT state SHALL be ignored.
REQ-026 FIN SHALL drive x_out/y_out/inf_out from Q, pulse done one cycle, drop busy the same cycle, return to IDLE.
REQ-027 x_out/y_out/inf_out SHALL hold until the next done; when inf_out=1, x_out=y_out=0.
REQ-028 k=0 SHALL yield done exactly n+1 cycles after start with inf_out=1.

Reset
REQ-029 reset low SHALL immediately force IDLE, busy=0, done=0, dbl_start=0, add_start=0, x_out=y_out=0, inf_out=0, q_inf=1, idx=0.
REQ-030 Reset mid-operation SHALL abandon the computation; late dbl_done/add_done afterwards SHALL be ignored.

Structure
REQ-031 Shared package ecc_pkg SHALL hold the FSM state type, default N=231 and IDX_W.
REQ-032 No sub-module SHALL be instantiated; point_doubling and point-addition units are instantiated by the parent and wired through the dbl_*/add_* ports.

Verification (n=8, p=17, a=2, px=5, py=1; behavioural doubler/adder models, 3-cycle latency)
REQ-033 k=1 -> no dbl_start/add_start, done with (5,1), inf_out=0.
REQ-034 k=2 -> one dbl_start, zero add_start, done with (6,3).
REQ-035 k=3 -> one dbl then one add, done with (10,6); k=19 -> inf_out=1, x_out=y_out=0.
REQ-036 k=0 -> done 9 cycles after start, inf_out=1, no sub-unit requests.
REQ-037 start pulsed while busy with k=3 -> ignored, first result unchanged (6,3) for k=2.
REQ-038 reset low during DBL_WAIT, stray dbl_done after release -> outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the elliptic-curve scalar multiplication datapath:
// the controller state type and the default operand/index widths.
package ecc_pkg;

  localparam int N     = 231;
  localparam int IDX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DBL_REQ,
    DBL_WAIT,
    ADD_CHK,
    ADD_REQ,
    ADD_WAIT,
    FIN
  } state_t;

endpackage

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add controller for Q = kP. It sequences external
// point-doubling and point-addition units through the dbl_*/add_* handshakes.
module scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int n     = N,
  parameter int IDX_W = ecc_pkg::IDX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] k,
  input  logic [n-1:0] px,
  input  logic [n-1:0] py,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] x_out,
  output logic [n-1:0] y_out,
  output logic         inf_out,
  output logic         dbl_start,
  output logic [n-1:0] dbl_x,
  output logic [n-1:0] dbl_y,
  input  logic         dbl_done,
  input  logic         dbl_inf,
  input  logic [n-1:0] dbl_x3,
  input  logic [n-1:0] dbl_y3,
  output logic         add_start,
  output logic [n-1:0] add_x1,
  output logic [n-1:0] add_y1,
  output logic [n-1:0] add_x2,
  output logic [n-1:0] add_y2,
  input  logic         add_done,
  input  logic         add_inf,
  input  logic [n-1:0] add_x3,
  input  logic [n-1:0] add_y3
);

  state_t           r_state;
  logic [n-1:0]     r_k;
  logic [n-1:0]     r_px;
  logic [n-1:0]     r_py;
  logic [n-1:0]     r_qx;
  logic [n-1:0]     r_qy;
  logic             r_q_inf;
  logic [IDX_W-1:0] r_idx;
  logic             r_skip;
  logic             r_busy;
  logic             r_done;
  logic             r_dbl_start;
  logic             r_add_start;
  logic [n-1:0]     r_x_out;
  logic [n-1:0]     r_y_out;
  logic             r_inf_out;

  logic [n-1:0]     w_k_sh;
  logic             w_kbit;
  logic             w_q_eq_p;
  state_t           w_next;

  // Current scalar bit; a shift avoids an index narrower than IDX_W.
  assign w_k_sh   = r_k >> r_idx;
  assign w_kbit   = w_k_sh[0];
  assign w_q_eq_p = (r_qx == r_px) && (r_qy == r_py);
  assign w_next   = (r_idx == '0) ? FIN : DBL_REQ;

  // Operands come straight from Q/P, which only change on a sampled done,
  // so they stay stable for the whole request.
  assign dbl_x     = r_qx;
  assign dbl_y     = r_qy;
  assign add_x1    = r_qx;
  assign add_y1    = r_qy;
  assign add_x2    = r_px;
  assign add_y2    = r_py;
  assign dbl_start = r_dbl_start;
  assign add_start = r_add_start;
  assign busy      = r_busy;
  assign done      = r_done;
  assign x_out     = r_x_out;
  assign y_out     = r_y_out;
  assign inf_out   = r_inf_out;

  // NOTE: state and every register use non-blocking assignments so all of
  // them update together from the values sampled at the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_qx        <= '0;
      r_qy        <= '0;
      r_q_inf     <= 1'b1;
      r_idx       <= '0;
      r_skip      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbl_start <= 1'b0;
      r_add_start <= 1'b0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_inf_out   <= 1'b0;
    end else begin
      // NOTE: pulses default low here so each branch only raises them.
      r_done      <= 1'b0;
      r_dbl_start <= 1'b0;
      r_add_start <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_k     <= k;
            r_px    <= px;
            r_py    <= py;
            r_idx   <= IDX_W'(n - 1);
            r_skip  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end

        SCAN: begin
          if (w_kbit) begin
            r_qx    <= r_px;
            r_qy    <= r_py;
            r_q_inf <= 1'b0;
            r_state <= (r_idx != '0) ? DBL_REQ : FIN;
          end else if (r_idx != '0) begin
            r_idx <= r_idx - IDX_W'(1);
          end else begin
            r_q_inf <= 1'b1;
            r_state <= FIN;
          end
        end

        DBL_REQ: begin
          r_idx <= r_idx - IDX_W'(1);
          if (r_q_inf) begin
            r_state <= ADD_CHK;
          end else begin
            r_dbl_start <= 1'b1;
            r_state     <= DBL_WAIT;
          end
        end

        DBL_WAIT: begin
          if (dbl_done) begin
            r_qx    <= dbl_x3;
            r_qy    <= dbl_y3;
            r_q_inf <= dbl_inf;
            r_state <= ADD_CHK;
          end
        end

        ADD_CHK: begin
          if (!w_kbit || r_skip) begin
            r_skip  <= 1'b0;
            r_state <= w_next;
          end else if (r_q_inf) begin
            r_qx    <= r_px;
            r_qy    <= r_py;
            r_q_inf <= 1'b0;
            r_state <= w_next;
          end else if (w_q_eq_p) begin
            // Q + P with Q == P is a doubling; the adder cannot handle it.
            r_skip      <= 1'b1;
            r_dbl_start <= 1'b1;
            r_state     <= DBL_WAIT;
          end else if (r_qx == r_px) begin
            r_q_inf <= 1'b1;
            r_state <= w_next;
          end else begin
            r_state <= ADD_REQ;
          end
        end

        ADD_REQ: begin
          r_add_start <= 1'b1;
          r_state     <= ADD_WAIT;
        end

        ADD_WAIT: begin
          if (add_done) begin
            r_qx    <= add_x3;
            r_qy    <= add_y3;
            r_q_inf <= add_inf;
            r_state <= w_next;
          end
        end

        FIN: begin
          r_x_out   <= r_q_inf ? '0 : r_qx;
          r_y_out   <= r_q_inf ? '0 : r_qy;
          r_inf_out <= r_q_inf;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl on y^2 = x^3 + 2x + 2 over GF(17), P = (5,1),
// with behavioural 3-cycle doubling/addition units.
module tb_scalar_mult_ctrl;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NB-1:0] k, px, py;
  logic          busy, done, inf_out;
  logic [NB-1:0] x_out, y_out;
  logic          dbl_start, dbl_done, dbl_inf;
  logic [NB-1:0] dbl_x, dbl_y, dbl_x3, dbl_y3;
  logic          add_start, add_done, add_inf;
  logic [NB-1:0] add_x1, add_y1, add_x2, add_y2, add_x3, add_y3;

  int checks   = 0;
  int failures = 0;
  int n_dbl_cnt, n_add_cnt, stab_err;

  always #5 clk = ~clk;

  scalar_mult_ctrl #(.n(NB), .IDX_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .px(px), .py(py),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out), .inf_out(inf_out),
    .dbl_start(dbl_start), .dbl_x(dbl_x), .dbl_y(dbl_y),
    .dbl_done(dbl_done), .dbl_inf(dbl_inf), .dbl_x3(dbl_x3), .dbl_y3(dbl_y3),
    .add_start(add_start), .add_x1(add_x1), .add_y1(add_y1),
    .add_x2(add_x2), .add_y2(add_y2),
    .add_done(add_done), .add_inf(add_inf), .add_x3(add_x3), .add_y3(add_y3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // GF(17) curve arithmetic for the behavioural units.
  function automatic int md(input int a);
    return ((a % 17) + 17) % 17;
  endfunction

  function automatic int inv(input int a);
    int r = 1;
    for (int i = 0; i < 15; i++) r = md(r * a);
    return r;
  endfunction

  task automatic pt_dbl(input int x, input int y, output int x3, output int y3, output bit inf);
    int lam;
    inf = (y == 0);
    lam = md((3 * x * x + 2) * inv(md(2 * y)));
    x3  = md(lam * lam - 2 * x);
    y3  = md(lam * (x - x3) - y);
  endtask

  task automatic pt_add(input int x1, input int y1, input int x2, input int y2,
                        output int x3, output int y3, output bit inf);
    int lam;
    if (x1 == x2) begin
      if (md(y1 + y2) == 0) begin
        inf = 1; x3 = 0; y3 = 0;
      end else begin
        pt_dbl(x1, y1, x3, y3, inf);
      end
    end else begin
      inf = 0;
      lam = md((y2 - y1) * inv(md(x2 - x1)));
      x3  = md(lam * lam - x1 - x2);
      y3  = md(lam * (x1 - x3) - y1);
    end
  endtask

  // Doubling unit model: operands latched on start, result 3 cycles later.
  int            dbl_cnt = 0;
  bit            dbl_track = 0;
  logic [NB-1:0] dbl_lx, dbl_ly;
  always @(negedge clk) begin
    int  rx, ry;
    bit  ri;
    dbl_done = 1'b0;
    if (dbl_cnt != 0) begin
      if (dbl_track && (dbl_x !== dbl_lx || dbl_y !== dbl_ly)) stab_err++;
      dbl_cnt--;
      if (dbl_cnt == 0) begin
        pt_dbl(int'(dbl_lx), int'(dbl_ly), rx, ry, ri);
        dbl_x3   = NB'(rx);
        dbl_y3   = NB'(ry);
        dbl_inf  = ri;
        dbl_done = 1'b1;
      end
    end
    if (dbl_start) begin
      dbl_lx    = dbl_x;
      dbl_ly    = dbl_y;
      dbl_cnt   = 3;
      dbl_track = 1;
      n_dbl_cnt++;
    end
  end

  int            add_cnt = 0;
  bit            add_track = 0;
  logic [NB-1:0] add_l1x, add_l1y, add_l2x, add_l2y;
  always @(negedge clk) begin
    int  rx, ry;
    bit  ri;
    add_done = 1'b0;
    if (add_cnt != 0) begin
      if (add_track && (add_x1 !== add_l1x || add_y1 !== add_l1y ||
                        add_x2 !== add_l2x || add_y2 !== add_l2y)) stab_err++;
      add_cnt--;
      if (add_cnt == 0) begin
        pt_add(int'(add_l1x), int'(add_l1y), int'(add_l2x), int'(add_l2y), rx, ry, ri);
        add_x3   = NB'(rx);
        add_y3   = NB'(ry);
        add_inf  = ri;
        add_done = 1'b1;
      end
    end
    if (add_start) begin
      add_l1x = add_x1; add_l1y = add_y1;
      add_l2x = add_x2; add_l2y = add_y2;
      add_cnt   = 3;
      add_track = 1;
      n_add_cnt++;
    end
  end

  // An operation abandoned by reset may legally see its operands change.
  always @(negedge reset) begin
    dbl_track = 0;
    add_track = 0;
  end

  // Issue one request and wait for done; an optional second start is driven
  // spur_at cycles later while the first computation is still running.
  task automatic run_k(input logic [NB-1:0] kk, input int spur_at, input logic [NB-1:0] spur_k,
                       output int lat);
    int c;
    n_dbl_cnt = 0;
    n_add_cnt = 0;
    @(negedge clk);
    k = kk; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("busy_after_start k=%0d", kk), busy, 1);
    c = 0;
    while (!done && c < 400) begin
      if (c == spur_at) begin start = 1'b1; k = spur_k; end
      else start = 1'b0;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    if (!done) check($sformatf("timeout k=%0d", kk), 0, 1);
    lat = c;
  endtask

  typedef struct {
    logic [NB-1:0] k;
    logic [NB-1:0] x;
    logic [NB-1:0] y;
    logic          inf;
    int            n_dbl;
    int            n_add;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, done_cnt, stray_cnt;
    stab_err = 0;
    reset = 1'b0; start = 1'b0; k = '0; px = 8'd5; py = 8'd1;
    dbl_done = 0; dbl_inf = 0; dbl_x3 = '0; dbl_y3 = '0;
    add_done = 0; add_inf = 0; add_x3 = '0; add_y3 = '0;

    vecs[0] = '{8'd1,   8'd5,  8'd1,  1'b0, 0, 0};
    vecs[1] = '{8'd2,   8'd6,  8'd3,  1'b0, 1, 0};
    vecs[2] = '{8'd3,   8'd10, 8'd6,  1'b0, 1, 1};
    vecs[3] = '{8'd19,  8'd0,  8'd0,  1'b1, 4, 1};
    vecs[4] = '{8'd0,   8'd0,  8'd0,  1'b1, 0, 0};
    vecs[5] = '{8'd21,  8'd6,  8'd3,  1'b0, 5, 1};
    vecs[6] = '{8'd38,  8'd0,  8'd0,  1'b1, 4, 1};
    vecs[7] = '{8'd39,  8'd5,  8'd1,  1'b0, 4, 1};
    vecs[8] = '{8'd255, 8'd13, 8'd7,  1'b0, 7, 7};
    vecs[9] = '{8'd100, 8'd9,  8'd16, 1'b0, 6, 2};

    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbl_start", dbl_start, 0);
    check("rst_add_start", add_start, 0);
    check("rst_outs", {x_out, y_out, 7'd0, inf_out}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_k(vecs[i].k, -1, '0, lat);
      check($sformatf("x k=%0d", vecs[i].k), x_out, vecs[i].x);
      check($sformatf("y k=%0d", vecs[i].k), y_out, vecs[i].y);
      check($sformatf("inf k=%0d", vecs[i].k), inf_out, vecs[i].inf);
      check($sformatf("busy_at_done k=%0d", vecs[i].k), busy, 0);
      check($sformatf("n_dbl k=%0d", vecs[i].k), n_dbl_cnt, vecs[i].n_dbl);
      check($sformatf("n_add k=%0d", vecs[i].k), n_add_cnt, vecs[i].n_add);
      if (vecs[i].k == 0) check("k0_latency", lat, NB + 1);
      repeat (2) @(negedge clk);
      check($sformatf("done_pulse k=%0d", vecs[i].k), done, 0);
      check($sformatf("x_hold k=%0d", vecs[i].k), x_out, vecs[i].x);
    end

    // A start while busy is dropped and not queued.
    run_k(8'd2, 2, 8'd3, lat);
    check("spur_x", x_out, 6);
    check("spur_y", y_out, 3);
    check("spur_n_add", n_add_cnt, 0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("spur_no_second_run", done_cnt, 0);

    // Reset while a doubling is outstanding; its late done must be ignored.
    run_k(8'd3, -1, '0, lat);
    @(negedge clk);
    k = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!dbl_start && lat < 100) begin @(negedge clk); lat++; end
    check("mid_dbl_start_seen", dbl_start, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_outs", {x_out, y_out, 7'd0, inf_out}, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    done_cnt  = 0;
    stray_cnt = 0;
    n_dbl_cnt = 0;
    n_add_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (dbl_done) stray_cnt++;
      if (done || busy) done_cnt++;
    end
    check("stray_dbl_done_driven", stray_cnt, 1);
    check("stray_no_done_busy", done_cnt, 0);
    check("stray_no_requests", n_dbl_cnt + n_add_cnt, 0);
    check("stray_outs", {x_out, y_out, 7'd0, inf_out}, 0);

    // The controller is back in IDLE and accepts a new request.
    run_k(8'd3, -1, '0, lat);
    check("post_rst_x", x_out, 10);
    check("post_rst_y", y_out, 6);

    check("operand_stability", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
